gray_step_monitor: RTL and testbench

Downstream consumer of the 4-bit Gray counter output. Registers each Gray-coded sample, decodes it to binary, and checks that consecutive samples differ by exactly one count, either up or down. It reports direction, wrap-around events and illegal jumps, and keeps a lock state machine plus a saturating error counter for the datapath that reads the counter.

---
 rtl/gray_step_monitor.sv | 150 +++++++++++++++
 tb/tb_gray_step_monitor.sv | 132 +++++++++++++
 2 files changed

// File: rtl/gray_step_monitor.sv
// Gray-coded step monitor: decodes each sample, classifies the step against the
// previous one, and tracks lock. Optional error counter: GRAY_STEP_MON_ERR_CNT_EN.
module gray_step_monitor #(
   parameter int WIDTH     = 4,
   parameter int LOCK_N    = 3,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 valid_in,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 bin_valid,
   output logic                 dir_up,
   output logic                 step_err,
   output logic                 wrap_pulse,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      TRACK  = 2'd1,
      RESYNC = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO_V = '0;
   localparam logic [WIDTH-1:0] MAX_V  = '1;
   localparam logic [3:0]       LOCK_V = 4'(LOCK_N);

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   state_t           state_r, state_s;
   logic [WIDTH-1:0] b_ref_r, ref_s;
   logic [3:0]       good_cnt_r, good_s;
   logic [WIDTH-1:0] bin_new_s, diff_s;
   logic             is_up_s, is_dn_s, is_hold_s;
   logic             dir_s, err_s, wrap_s, bv_s;

   assign bin_new_s = gray2bin(gray_in);
   assign diff_s    = bin_new_s - b_ref_r;
   assign is_hold_s = (diff_s == ZERO_V);
   assign is_up_s   = (diff_s == ONE_V);
   assign is_dn_s   = (diff_s == MAX_V);
   assign bin_out   = b_ref_r;

   // Next-state and next-output decode for one accepted sample.
   always_comb begin
      state_s = state_r;
      ref_s   = b_ref_r;
      good_s  = good_cnt_r;
      dir_s   = dir_up;
      err_s   = 1'b0;
      wrap_s  = 1'b0;
      bv_s    = 1'b0;
      if (valid_in) begin
         bv_s = 1'b1;
         case (state_r)
            EMPTY: begin
               ref_s   = bin_new_s;
               state_s = TRACK;
            end
            TRACK: begin
               if (is_up_s || is_dn_s) begin
                  ref_s  = bin_new_s;
                  dir_s  = is_up_s;
                  wrap_s = (is_up_s && (b_ref_r == MAX_V)) || (is_dn_s && (b_ref_r == ZERO_V));
               end else if (is_hold_s) begin
                  ref_s = b_ref_r;
               end else begin
                  ref_s   = bin_new_s;
                  err_s   = 1'b1;
                  good_s  = 4'd0;
                  state_s = RESYNC;
               end
            end
            RESYNC: begin
               ref_s = bin_new_s;
               if (is_up_s || is_dn_s) begin
                  dir_s  = is_up_s;
                  wrap_s = (is_up_s && (b_ref_r == MAX_V)) || (is_dn_s && (b_ref_r == ZERO_V));
                  good_s = good_cnt_r + 4'd1;
                  if (good_s >= LOCK_V) begin
                     state_s = TRACK;
                  end else begin
                     state_s = RESYNC;
                  end
               end else if (is_hold_s) begin
                  good_s = good_cnt_r;
               end else begin
                  err_s  = 1'b1;
                  good_s = 4'd0;
               end
            end
            default: begin
               state_s = EMPTY;
            end
         endcase
      end else begin
         bv_s = 1'b0;
      end
   end

   // State, reference and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= EMPTY;
         b_ref_r    <= '0;
         good_cnt_r <= 4'd0;
         bin_valid  <= 1'b0;
         dir_up     <= 1'b0;
         step_err   <= 1'b0;
         wrap_pulse <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state_r    <= state_s;
         b_ref_r    <= ref_s;
         good_cnt_r <= good_s;
         bin_valid  <= bv_s;
         dir_up     <= dir_s;
         step_err   <= err_s;
         wrap_pulse <= wrap_s;
         locked     <= (state_s == TRACK);
      end
   end

`ifdef GRAY_STEP_MON_ERR_CNT_EN
   // Saturating count of detected illegal steps.
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_count <= '0;
      end else if (err_s && (err_count != {ERR_CNT_W{1'b1}})) begin
         err_count <= err_count + ERR_CNT_W'(1);
      end else begin
         err_count <= err_count;
      end
   end
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_gray_step_monitor.sv
// Table-driven scoreboard bench for gray_step_monitor (ERR_CNT_W = 2 to reach saturation).
module tb_gray_step_monitor;

   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          valid_in = 1'b0;
   logic [3:0]    gray_in = 4'd0;
   logic [3:0]    bin_out;
   logic          bin_valid, dir_up, step_err, wrap_pulse, locked;
   logic [CW-1:0] err_count;

   gray_step_monitor #(.WIDTH(4), .LOCK_N(3), .ERR_CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .gray_in(gray_in), .valid_in(valid_in),
      .bin_out(bin_out), .bin_valid(bin_valid), .dir_up(dir_up), .step_err(step_err),
      .wrap_pulse(wrap_pulse), .locked(locked), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic [3:0] g;
      logic [3:0] bin;
      logic       bv;
      logic       dir;
      logic       err;
      logic       wrap;
      logic       lock;
      logic [1:0] cnt;
   } vec_t;

   logic [12:0] sb_q[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [1:0] exp_cnt(input logic [1:0] c);
`ifdef GRAY_STEP_MON_ERR_CNT_EN
      return c;
`else
      return 2'd0 & c;
`endif
   endfunction

   task automatic run(input string name, input int idx, input vec_t e);
      logic [12:0] exp_v, act_v;
      @(negedge clk);
      reset    = ~e.rst;
      valid_in = e.v;
      gray_in  = e.g;
      sb_q.push_back({e.bin, e.bv, e.dir, e.err, e.wrap, e.lock, exp_cnt(e.cnt)});
      @(posedge clk);
      #1;
      exp_v = sb_q.pop_front();
      act_v = {bin_out, bin_valid, dir_up, step_err, wrap_pulse, locked, err_count};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s[%0d] {bin,bv,dir,err,wrap,lock,cnt} got %b want %b", name, idx, act_v, exp_v);
      end
   endtask

   vec_t vecs[35];
   vec_t hand[4];

   initial begin
      // rst, v, gray, bin, bv, dir, err, wrap, lock, cnt
      vecs = '{
         '{1'b1, 1'b0, 4'b0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
         '{1'b0, 1'b1, 4'b0000, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b0001, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b0011, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b0010, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b0, 1'b0, 4'b1111, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b1, 1'b1, 4'b0110, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
         '{1'b0, 1'b1, 4'b1011, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b1001, 4'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b1000, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b0000, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b1000, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b1001, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b1000, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b0000, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0},
         '{1'b0, 1'b1, 4'b0101, 4'd6,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1},
         '{1'b0, 1'b1, 4'b0100, 4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1},
         '{1'b0, 1'b1, 4'b0110, 4'd4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2},
         '{1'b0, 1'b1, 4'b0010, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2},
         '{1'b0, 1'b1, 4'b0011, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2},
         '{1'b0, 1'b1, 4'b0001, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2},
         '{1'b0, 1'b1, 4'b1111, 4'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b1, 4'b1111, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b1, 4'b1111, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b1, 4'b1111, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b1, 4'b1111, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b1, 4'b1111, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b0, 4'b0000, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b1, 4'b1110, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b1, 4'b1010, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b1, 4'b1011, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3},
         '{1'b0, 1'b1, 4'b0000, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3},
         '{1'b0, 1'b1, 4'b0101, 4'd6,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3},
         '{1'b1, 1'b1, 4'b0101, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
         '{1'b0, 1'b1, 4'b0101, 4'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}
      };
      // Wrap pulses while resynchronising, then relock on the third good step.
      hand = '{
         '{1'b0, 1'b1, 4'b1000, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1},
         '{1'b0, 1'b1, 4'b0000, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1},
         '{1'b0, 1'b1, 4'b1000, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1},
         '{1'b0, 1'b1, 4'b1001, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1}
      };

      for (int i = 0; i < 35; i++) begin
         run("table", i, vecs[i]);
      end
      for (int i = 0; i < 4; i++) begin
         run("resync_wrap", i, hand[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
